// File: rtl/arith_pkg.sv
// Shared opcode encoding, dispatcher states and default widths for the arithmetic unit cluster.
// The result multiplexer decodes its selector with the same OP_* constants.
package arith_pkg;

  localparam int NBitsDefault = 16;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_SQR  = 2'b10;
  localparam logic [1:0] OP_INV  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE,
    ST_FAIL
  } dispatch_state_e;

endpackage

// File: rtl/op_timeout_counter.sv
// Watchdog counter for the dispatcher's WAIT state: clears on demand, counts while enabled,
// and holds at TimeoutCycles, where it raises the terminal flag.
module op_timeout_counter #(
  parameter int TimeoutCycles = 255,
  localparam int CntW         = $clog2(TimeoutCycles + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic terminal_o
);

  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_d;

  assign terminal_o = (count_q == CntW'(TimeoutCycles));

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !terminal_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/arith_op_dispatcher.sv
// Control-side dispatcher for the mult/div/sqrt cores: validates a request, pulses the chosen
// unit's start, steers the result mux, and captures the result or aborts on fault/timeout.
module arith_op_dispatcher
  import arith_pkg::*;
#(
  parameter int NBits         = NBitsDefault,
  parameter int TimeoutCycles = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [NBits-1:0] DataX,
  input  logic [NBits-1:0] DataY,
  input  logic             Done_Mult,
  input  logic             Done_Div,
  input  logic             Done_SQR,
  input  logic [NBits-1:0] Result_In,
  output logic             Start_Mult,
  output logic             Start_Div,
  output logic             Start_SQR,
  output logic [NBits-1:0] OpX,
  output logic [NBits-1:0] OpY,
  output logic [1:0]       Selector,
  output logic [NBits-1:0] Result,
  output logic             Busy,
  output logic             Done,
  output logic             Error
);

  dispatch_state_e state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [NBits-1:0] opX_q, opX_d;
  logic [NBits-1:0] opY_q, opY_d;
  logic [NBits-1:0] result_q, result_d;
  logic             error_q, error_d;
  logic             cntClear;
  logic             cntEnable;
  logic             timedOut;
  logic             unitDone;

  op_timeout_counter #(
    .TimeoutCycles(TimeoutCycles)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (cntClear),
    .enable_i  (cntEnable),
    .terminal_o(timedOut)
  );

  // Only the unit currently selected may complete the operation.
  always_comb begin
    unitDone = 1'b0;
    case (sel_q)
      OP_MULT: unitDone = Done_Mult;
      OP_DIV:  unitDone = Done_Div;
      OP_SQR:  unitDone = Done_SQR;
      default: unitDone = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    opX_d     = opX_q;
    opY_d     = opY_q;
    result_d  = result_q;
    error_d   = error_q;
    cntClear  = 1'b0;
    cntEnable = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if (Op == OP_INV || (Op == OP_DIV && DataY == '0)) begin
            error_d = 1'b1;
            state_d = ST_FAIL;
          end else begin
            sel_d   = Op;
            opX_d   = DataX;
            opY_d   = DataY;
            error_d = 1'b0;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        cntClear = 1'b1;
        state_d  = ST_WAIT;
      end
      // A completing unit wins over a timeout that expires in the same cycle.
      ST_WAIT: begin
        cntEnable = 1'b1;
        if (unitDone) begin
          result_d = Result_In;
          state_d  = ST_CAPTURE;
        end else if (timedOut) begin
          error_d = 1'b1;
          state_d = ST_FAIL;
        end
      end
      ST_CAPTURE: state_d = ST_IDLE;
      ST_FAIL:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sel_q    <= OP_MULT;
      opX_q    <= '0;
      opY_q    <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      opX_q    <= opX_d;
      opY_q    <= opY_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  assign Start_Mult = (state_q == ST_ISSUE) && (sel_q == OP_MULT);
  assign Start_Div  = (state_q == ST_ISSUE) && (sel_q == OP_DIV);
  assign Start_SQR  = (state_q == ST_ISSUE) && (sel_q == OP_SQR);
  assign OpX        = opX_q;
  assign OpY        = opY_q;
  assign Selector   = sel_q;
  assign Result     = result_q;
  assign Busy       = (state_q != ST_IDLE);
  assign Done       = (state_q == ST_CAPTURE) || (state_q == ST_FAIL);
  assign Error      = error_q;

endmodule

// File: tb/tb_arith_op_dispatcher.sv
// Transaction-level bench for arith_op_dispatcher: the bench plays the three arithmetic units
// and predicts every outcome from the operation rules and cycle timing.
module tb_arith_op_dispatcher;
  import arith_pkg::*;

  localparam int NB = 16;
  localparam int TO = 255;

  logic          clk = 1'b0;
  logic          reset;
  logic          Start;
  logic [1:0]    Op;
  logic [NB-1:0] DataX;
  logic [NB-1:0] DataY;
  logic          Done_Mult;
  logic          Done_Div;
  logic          Done_SQR;
  logic [NB-1:0] Result_In;
  logic          Start_Mult;
  logic          Start_Div;
  logic          Start_SQR;
  logic [NB-1:0] OpX;
  logic [NB-1:0] OpY;
  logic [1:0]    Selector;
  logic [NB-1:0] Result;
  logic          Busy;
  logic          Done;
  logic          Error;

  int vectors     = 0;
  int miscompares = 0;

  logic [NB-1:0] expResult;
  logic [1:0]    expSel;
  logic          expErr;

  arith_op_dispatcher #(
    .NBits(NB),
    .TimeoutCycles(TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Start     (Start),
    .Op        (Op),
    .DataX     (DataX),
    .DataY     (DataY),
    .Done_Mult (Done_Mult),
    .Done_Div  (Done_Div),
    .Done_SQR  (Done_SQR),
    .Result_In (Result_In),
    .Start_Mult(Start_Mult),
    .Start_Div (Start_Div),
    .Start_SQR (Start_SQR),
    .OpX       (OpX),
    .OpY       (OpY),
    .Selector  (Selector),
    .Result    (Result),
    .Busy      (Busy),
    .Done      (Done),
    .Error     (Error)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [NB-1:0] refResult(input logic [1:0] op, input logic [NB-1:0] x,
                                               input logic [NB-1:0] y);
    logic [31:0] prod;
    int r;
    case (op)
      OP_MULT: begin
        prod = 32'(x) * 32'(y);
        return prod[NB-1:0];
      end
      OP_DIV:  return (y == '0) ? '0 : x / y;
      OP_SQR: begin
        r = 0;
        while ((r + 1) * (r + 1) <= int'(x)) r++;
        return NB'(r);
      end
      default: return '0;
    endcase
  endfunction

  function automatic logic [2:0] pulseFor(input logic [1:0] op);
    case (op)
      OP_MULT: return 3'b100;
      OP_DIV:  return 3'b010;
      OP_SQR:  return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic driveUnitDone(input logic [1:0] unit);
    case (unit)
      OP_MULT: Done_Mult = 1'b1;
      OP_DIV:  Done_Div  = 1'b1;
      OP_SQR:  Done_SQR  = 1'b1;
      default: ;
    endcase
  endtask

  task automatic clearUnitDone();
    Done_Mult = 1'b0;
    Done_Div  = 1'b0;
    Done_SQR  = 1'b0;
  endtask

  // One complete request from IDLE back to IDLE, acting as the arithmetic unit meanwhile.
  task automatic applyStimulus(input logic [1:0] op, input logic [NB-1:0] x, input logic [NB-1:0] y,
                               input int latency, input bit neverDone, input bit spurious,
                               input bit busyStart);
    logic [NB-1:0] res;
    int waitCycles;
    int other;
    res   = refResult(op, x, y);
    Start = 1'b1;
    Op    = op;
    DataX = x;
    DataY = y;
    @(negedge clk);
    Start = 1'b0;
    Op    = 2'($urandom);
    DataX = NB'($urandom);
    DataY = NB'($urandom);
    if (op == OP_INV || (op == OP_DIV && y == '0)) begin
      expErr = 1'b1;
      checkOutput("faultDone", 32'(Done), 32'd1);
      checkOutput("faultError", 32'(Error), 32'd1);
      checkOutput("faultNoPulse", 32'({Start_Mult, Start_Div, Start_SQR}), 32'd0);
      checkOutput("faultResultHeld", 32'(Result), 32'(expResult));
      checkOutput("faultSelectorHeld", 32'(Selector), 32'(expSel));
      @(negedge clk);
      checkOutput("faultBusyAfter", 32'(Busy), 32'd0);
      checkOutput("faultDoneAfter", 32'(Done), 32'd0);
      checkOutput("faultErrorSticky", 32'(Error), 32'd1);
      return;
    end
    expSel = op;
    expErr = 1'b0;
    checkOutput("issueBusy", 32'(Busy), 32'd1);
    checkOutput("issuePulse", 32'({Start_Mult, Start_Div, Start_SQR}), 32'(pulseFor(op)));
    checkOutput("issueSelector", 32'(Selector), 32'(op));
    checkOutput("issueOpX", 32'(OpX), 32'(x));
    checkOutput("issueOpY", 32'(OpY), 32'(y));
    checkOutput("issueErrorCleared", 32'(Error), 32'd0);
    checkOutput("issueDone", 32'(Done), 32'd0);
    @(negedge clk);
    waitCycles = neverDone ? TO + 1 : latency;
    for (int i = 0; i < waitCycles; i++) begin
      checkOutput("waitBusy", 32'(Busy), 32'd1);
      checkOutput("waitDone", 32'(Done), 32'd0);
      checkOutput("waitNoPulse", 32'({Start_Mult, Start_Div, Start_SQR}), 32'd0);
      if (i == 0) begin
        checkOutput("waitOperandsStable", 32'({Selector, OpX, OpY}), 32'({op, x, y}));
      end
      Result_In = ~res;
      if (!neverDone && i == waitCycles - 1) begin
        driveUnitDone(op);
        Result_In = res;
      end else if (spurious) begin
        other = (int'(op) + 1 + (i % 2)) % 3;
        driveUnitDone(2'(other));
      end
      if (busyStart && i == 0) begin
        Start = 1'b1;
        Op    = OP_MULT;
        DataX = NB'($urandom);
        DataY = NB'($urandom);
      end
      @(negedge clk);
      Start = 1'b0;
      clearUnitDone();
      Result_In = NB'($urandom);
    end
    if (neverDone) begin
      expErr = 1'b1;
      checkOutput("timeoutDone", 32'(Done), 32'd1);
      checkOutput("timeoutError", 32'(Error), 32'd1);
      checkOutput("timeoutResultHeld", 32'(Result), 32'(expResult));
    end else begin
      expResult = res;
      checkOutput("captureDone", 32'(Done), 32'd1);
      checkOutput("captureError", 32'(Error), 32'd0);
      checkOutput("captureResult", 32'(Result), 32'(res));
      checkOutput("captureSelector", 32'(Selector), 32'(op));
    end
    checkOutput("completeBusy", 32'(Busy), 32'd1);
    @(negedge clk);
    checkOutput("idleBusy", 32'(Busy), 32'd0);
    checkOutput("idleDone", 32'(Done), 32'd0);
    checkOutput("idleError", 32'(Error), 32'(expErr));
    checkOutput("idleResult", 32'(Result), 32'(expResult));
  endtask

  initial begin
    logic [1:0]    rOp;
    logic [NB-1:0] rX;
    logic [NB-1:0] rY;
    reset     = 1'b1;
    Start     = 1'b0;
    Op        = 2'b00;
    DataX     = '0;
    DataY     = '0;
    Result_In = '0;
    clearUnitDone();
    expResult = '0;
    expSel    = OP_MULT;
    expErr    = 1'b0;

    @(negedge clk);
    checkOutput("resetState",
                32'({Busy, Done, Error, Start_Mult, Start_Div, Start_SQR, Selector}), 32'd0);
    checkOutput("resetOperands", 32'({OpX, OpY}), 32'd0);
    checkOutput("resetResult", 32'(Result), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(OP_MULT, 16'd12, 16'd5, 4, 1'b0, 1'b0, 1'b0);
    applyStimulus(OP_DIV, 16'd100, 16'd0, 1, 1'b0, 1'b0, 1'b0);
    applyStimulus(OP_SQR, 16'd144, 16'd0, 3, 1'b0, 1'b1, 1'b0);
    applyStimulus(OP_DIV, 16'd9, 16'd3, 1, 1'b1, 1'b0, 1'b0);

    Start = 1'b1;
    Op    = OP_SQR;
    DataX = 16'd400;
    DataY = 16'd0;
    @(negedge clk);
    Start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("asyncResetState",
                32'({Busy, Done, Error, Start_Mult, Start_Div, Start_SQR, Selector}), 32'd0);
    checkOutput("asyncResetOperands", 32'({OpX, OpY}), 32'd0);
    checkOutput("asyncResetResult", 32'(Result), 32'd0);
    expResult = '0;
    expSel    = OP_MULT;
    expErr    = 1'b0;
    @(negedge clk);
    reset    = 1'b0;
    Done_SQR = 1'b1;
    @(negedge clk);
    Done_SQR = 1'b0;
    checkOutput("postResetNoDone", 32'({Busy, Done}), 32'd0);
    @(negedge clk);
    checkOutput("postResetStillIdle", 32'({Busy, Done, Result}), 32'd0);

    applyStimulus(OP_MULT, 16'd7, 16'd6, 2, 1'b0, 1'b0, 1'b0);
    applyStimulus(OP_INV, 16'd5, 16'd5, 1, 1'b0, 1'b0, 1'b0);
    applyStimulus(OP_DIV, 16'd1000, 16'd7, 5, 1'b0, 1'b1, 1'b1);
    applyStimulus(OP_SQR, 16'd0, 16'd0, 1, 1'b0, 1'b0, 1'b0);
    applyStimulus(OP_MULT, 16'hFFFF, 16'hFFFF, 1, 1'b0, 1'b1, 1'b1);

    for (int t = 0; t < 40; t++) begin
      rOp = 2'($urandom_range(0, 3));
      rX  = NB'($urandom);
      rY  = ($urandom_range(0, 3) == 0) ? '0 : NB'($urandom);
      applyStimulus(rOp, rX, rY, $urandom_range(1, 6), 1'b0,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        Op    = 2'($urandom);
        DataX = NB'($urandom);
        @(negedge clk);
        checkOutput("idleHold", 32'({Busy, Done, Error, Selector, Result}),
                    32'({1'b0, 1'b0, expErr, expSel, expResult}));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
